// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// FSM state encoding and a constant-evaluable ceil(log2) helper.
package seq_multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_e;

  // ceil(log2(value)), never less than 1 so a counter always has a bit.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_multiplier_nbit_adder.sv
// Parametrised ripple-carry adder; one full-adder cell per bit.
module nbit_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign sum[gi]       = a[gi] ^ b[gi] ^ carry[gi];
    assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
  end

  assign cout = carry[WIDTH];

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-and-add multiplier, one partial product per clock.
// Signed operation multiplies magnitudes and negates the final product.
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  localparam int CW = clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  mult_state_e        state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] p_q, p_d;

  logic               sm_eff;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH-1:0]   add_b;
  logic [WIDTH-1:0]   add_sum;
  logic               add_cout;
  logic [2*WIDTH-1:0] product;

  // Operand conditioning: magnitudes only when signed mode is effective.
  // The most-negative value negates to itself, which as unsigned is 2^(W-1).
  always_comb begin
    sm_eff = signed_mode & SIGNED_EN;
    a_neg  = sm_eff & a[WIDTH-1];
    b_neg  = sm_eff & b[WIDTH-1];
    a_mag  = a_neg ? -a : a;
    b_mag  = b_neg ? -b : b;
  end

  // Partial product is gated to zero when the multiplier LSB is clear.
  assign add_b = mplier_q[0] ? mcand_q : '0;

  nbit_adder #(
    .WIDTH(WIDTH)
  ) u_acc_adder (
    .a   (acc_q),
    .b   (add_b),
    .cin (1'b0),
    .sum (add_sum),
    .cout(add_cout)
  );

  assign product = {acc_q, mplier_q};

  // Next-state logic: accept in IDLE, iterate in RUN, publish in DONE.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    done_d   = 1'b0;
    p_d      = p_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = a_mag;
          mplier_d = b_mag;
          acc_d    = '0;
          cnt_d    = CNT_LOAD;
          neg_d    = a_neg ^ b_neg;
          state_d  = RUN;
        end
      end
      RUN: begin
        // Shift {carry, acc, multiplier} right; the multiplier register
        // fills with the low product bits as its own bits are consumed.
        acc_d    = {add_cout, add_sum[WIDTH-1:1]};
        mplier_d = {add_sum[0], mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q - CNT_ONE;
        if (cnt_q == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        p_d     = neg_q ? -product : product;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      done_q   <= 1'b0;
      p_q      <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      done_q   <= done_d;
      p_q      <= p_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign p    = p_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: three instances (8-bit signed-capable,
// 8-bit with signed mode disabled, 4-bit signed-capable) share clk/rst_n.
module tb_seq_multiplier;

  logic        clk;
  logic        rst_n;
  logic        start_s [3];
  logic        mode_s  [3];
  logic [7:0]  a_s     [3];
  logic [7:0]  b_s     [3];
  logic        busy_w  [3];
  logic        done_w  [3];
  logic [15:0] p8s;
  logic [15:0] p8u;
  logic [7:0]  p4;

  int tests_run;
  int tests_failed;

  seq_multiplier #(.WIDTH(8), .SIGNED_EN(1'b1)) u_m8s (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .signed_mode(mode_s[0]),
    .a(a_s[0]), .b(b_s[0]), .busy(busy_w[0]), .done(done_w[0]), .p(p8s)
  );

  seq_multiplier #(.WIDTH(8), .SIGNED_EN(1'b0)) u_m8u (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .signed_mode(mode_s[1]),
    .a(a_s[1]), .b(b_s[1]), .busy(busy_w[1]), .done(done_w[1]), .p(p8u)
  );

  seq_multiplier #(.WIDTH(4), .SIGNED_EN(1'b1)) u_m4 (
    .clk(clk), .rst_n(rst_n), .start(start_s[2]), .signed_mode(mode_s[2]),
    .a(a_s[2][3:0]), .b(b_s[2][3:0]), .busy(busy_w[2]), .done(done_w[2]), .p(p4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] p_of(input int inst);
    if (inst == 0) return p8s;
    if (inst == 1) return p8u;
    return {8'h00, p4};
  endfunction

  function automatic int width_of(input int inst);
    return (inst == 2) ? 4 : 8;
  endfunction

  // One full transaction with latency and handshake checks.
  task automatic run_op(input int inst, input logic mode, input logic [7:0] av,
                        input logic [7:0] bv, input logic [15:0] exp, input string tag);
    int lat;
    lat = 0;
    start_s[inst] = 1'b1;
    mode_s[inst]  = mode;
    a_s[inst]     = av;
    b_s[inst]     = bv;
    @(posedge clk); #1;
    start_s[inst] = 1'b0;
    mode_s[inst]  = ~mode;
    a_s[inst]     = 8'hA5;
    b_s[inst]     = 8'h5A;
    check({tag, "_busy"}, 32'(busy_w[inst]), 32'd1);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done_w[inst]) begin
        lat = k;
        break;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'(width_of(inst) + 1));
    check({tag, "_p"}, 32'(p_of(inst)), 32'(exp));
    @(posedge clk); #1;
    check({tag, "_done_low"}, 32'(done_w[inst]), 32'd0);
    check({tag, "_idle"}, 32'(busy_w[inst]), 32'd0);
    check({tag, "_p_hold"}, 32'(p_of(inst)), 32'(exp));
    $display("[TB] inst%0d %s a=0x%0h b=0x%0h signed=%0b p=0x%0h latency=%0d",
             inst, tag, av, bv, mode, p_of(inst), lat);
  endtask

  // Start an operation, then assert reset just after the 4th RUN edge.
  task automatic reset_mid(input int inst, input logic [7:0] av, input logic [7:0] bv,
                           input string tag);
    start_s[inst] = 1'b1;
    mode_s[inst]  = 1'b0;
    a_s[inst]     = av;
    b_s[inst]     = bv;
    @(posedge clk); #1;
    start_s[inst] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check({tag, "_rst_busy"}, 32'(busy_w[inst]), 32'd0);
    check({tag, "_rst_done"}, 32'(done_w[inst]), 32'd0);
    check({tag, "_rst_p"}, 32'(p_of(inst)), 32'd0);
    $display("[TB] inst%0d %s reset mid-run p=0x%0h busy=%0b", inst, tag, p_of(inst), busy_w[inst]);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Back-to-back: pulse then hold start; second request accepted at T+10.
  task automatic handshake();
    int ndone;
    ndone = 0;
    start_s[0] = 1'b1;
    mode_s[0]  = 1'b0;
    a_s[0]     = 8'd5;
    b_s[0]     = 8'd6;
    @(posedge clk); #1;
    a_s[0] = 8'd2;
    b_s[0] = 8'd3;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (k == 10) begin
        check("hs_reaccept_busy", 32'(busy_w[0]), 32'd1);
        start_s[0] = 1'b0;
      end
      if (done_w[0]) begin
        ndone++;
        if (ndone == 1) begin
          check("hs_first_edge", 32'(k), 32'd9);
          check("hs_first_p", 32'(p8s), 32'd30);
          $display("[TB] inst0 handshake first p=%0d at T+%0d", p8s, k);
        end else if (ndone == 2) begin
          check("hs_second_edge", 32'(k), 32'd19);
          check("hs_second_p", 32'(p8s), 32'd6);
          $display("[TB] inst0 handshake second p=%0d at T+%0d", p8s, k);
        end
      end
    end
    check("hs_done_count", 32'(ndone), 32'd2);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start_s[i] = 1'b0;
      mode_s[i]  = 1'b0;
      a_s[i]     = 8'h00;
      b_s[i]     = 8'h00;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_busy%0d", i), 32'(busy_w[i]), 32'd0);
      check($sformatf("reset_done%0d", i), 32'(done_w[i]), 32'd0);
      check($sformatf("reset_p%0d", i), 32'(p_of(i)), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(0, 1'b0, 8'd13,  8'd11,  16'd143,   "u8_13x11");
    run_op(0, 1'b0, 8'd255, 8'd255, 16'hFE01,  "u8_255x255");
    run_op(0, 1'b1, 8'hFD,  8'd7,   16'hFFEB,  "s8_m3x7");
    run_op(0, 1'b1, 8'd7,   8'hFD,  16'hFFEB,  "s8_7xm3");
    run_op(0, 1'b1, 8'h80,  8'h80,  16'h4000,  "s8_m128xm128");
    run_op(0, 1'b1, 8'hFF,  8'hFF,  16'h0001,  "s8_m1xm1");
    run_op(0, 1'b1, 8'h00,  8'h80,  16'h0000,  "s8_0xm128");
    run_op(0, 1'b1, 8'h80,  8'd127, 16'hC080,  "s8_m128x127");
    run_op(1, 1'b1, 8'hFD,  8'd7,   16'd1771,  "nosign_FDx7");
    run_op(1, 1'b0, 8'd255, 8'd255, 16'hFE01,  "nosign_255x255");
    run_op(2, 1'b0, 8'd15,  8'd15,  16'd225,   "u4_15x15");
    run_op(2, 1'b1, 8'h8,   8'h8,   16'h0040,  "s4_m8xm8");
    run_op(2, 1'b1, 8'h8,   8'h7,   16'h00C8,  "s4_m8x7");

    handshake();
    @(posedge clk); #1;

    reset_mid(0, 8'd200, 8'd100, "rst8");
    run_op(0, 1'b0, 8'd9, 8'd9, 16'd81, "u8_9x9_after_rst");
    reset_mid(2, 8'd15, 8'd15, "rst4");
    run_op(2, 1'b0, 8'd15, 8'd15, 16'd225, "u4_15x15_after_rst");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
